// File: rtl/hdt_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdt_pkg;

    // Controller states: normal issue, or waiting for the PC update unit.
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_PC_WAIT = 1'b1
    } hdt_state_e;

    localparam logic [3:0] REG_ZERO     = 4'h0;
    localparam logic [3:0] REG_DS       = 4'hE;
    localparam int         PEND_CYC_DEF = 3;

    // Counter width able to hold 0..cyc; never narrower than one bit.
    function automatic int pend_width(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/hdt_scoreboard.sv
// Per-register pending-write scoreboard: 16 down-counters, R0 hard-wired idle.
// Latency: lookups are combinational; a load is visible from the next cycle.
// Backpressure: none; the owner decides when a load happens.
module hdt_scoreboard
    import hdt_pkg::*;
#(
    parameter int PEND_CYC = PEND_CYC_DEF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rs_addr,
    input  logic [3:0] rt_addr,
    input  logic [3:0] rd_addr,
    input  logic       load_en,
    input  logic [3:0] load_addr,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       rd_busy
);

    localparam int PW = pend_width(PEND_CYC);

    logic [PW-1:0] pend [16];

    // Count every pending entry down; a fresh load beats the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                pend[r] <= '0;
            end
        end else begin
            // R0 is never written, so it can never be pending.
            pend[0] <= '0;
            for (int r = 1; r < 16; r++) begin
                if (load_en && (load_addr == 4'(r))) begin
                    pend[r] <= PW'(PEND_CYC);
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - PW'(1);
                end
            end
        end
    end

    assign rs_busy = (pend[rs_addr] != '0);
    assign rt_busy = (pend[rt_addr] != '0);
    assign rd_busy = (pend[rd_addr] != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ID-stage stall/bubble/flush control: scoreboard data hazards plus PC-update wait.
// Latency: outputs combinational from state/scoreboard/inputs; state moves next edge.
// Backpressure: stall_id holds PC and IF/ID; optional PIPE_STALL_STATS_EN adds stall_cnt.
module pipe_stall_ctrl
    import hdt_pkg::*;
#(
    parameter int PEND_CYC = PEND_CYC_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_wr_en,
    input  logic        id_uses_ds,
    input  logic        id_branch,
    input  logic        id_call,
    input  logic        id_ret,
    input  logic        pc_update,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_if,
`ifdef PIPE_STALL_STATS_EN
    output logic        issue,
    output logic [15:0] stall_cnt
`else
    output logic        issue
`endif
);

    hdt_state_e state_q;
    hdt_state_e state_d;

    logic [3:0] rs_eff;
    logic       rs_busy;
    logic       rt_busy;
    logic       rd_busy;
    logic       data_hz;
    logic       sb_load;

    logic       issue_c;
    logic       stall_c;
    logic       bubble_c;
    logic       flush_c;

    // Data-segment addressing reads R14 in place of rs.
    assign rs_eff = id_uses_ds ? REG_DS : id_rs;

    hdt_scoreboard #(
        .PEND_CYC (PEND_CYC)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_eff),
        .rt_addr   (id_rt),
        .rd_addr   (id_rd),
        .load_en   (sb_load),
        .load_addr (id_rd),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .rd_busy   (rd_busy)
    );

    // Calls and returns go out without an operand check; everything else
    // waits for its sources and its destination (WAW) to clear.
    assign data_hz = id_valid & ~id_call & ~id_ret & (rs_busy | rt_busy | rd_busy);

    // State register; reset also pulls the FSM out of a pending PC wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and raw outputs; RUN issues on clean operands, PC_WAIT freezes the front end.
    always_comb begin
        state_d  = state_q;
        issue_c  = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue_c  = id_valid & ~data_hz;
                stall_c  = data_hz;
                bubble_c = data_hz;
                // A redirect whose target is already known needs no wait.
                if (issue_c && (id_branch || id_ret) && !pc_update) begin
                    state_d = ST_PC_WAIT;
                end
            end
            ST_PC_WAIT: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                flush_c  = 1'b1;
                if (pc_update) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset forces every output low without waiting for a clock edge.
    assign issue     = ~rst & issue_c;
    assign stall_id  = ~rst & stall_c;
    assign bubble_ex = ~rst & bubble_c;
    assign flush_if  = ~rst & flush_c;

    // Only writes to a real register mark it pending.
    assign sb_load = issue & id_wr_en & (id_rd != REG_ZERO);

`ifdef PIPE_STALL_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = rst ? 16'h0000 : stall_cnt_q;
`endif

endmodule
